// File: rtl/uart_alu_sequencer_if.sv
// Signal bundle between the UART-ALU sequencer and its uart_rx / alu / uart_tx neighbours.
// slave = the sequencer side, master = the surrounding datapath (or a testbench).
interface uart_alu_sequencer_if #(
  parameter int N_BITS  = 8,
  parameter int OP_BITS = 6
);
  logic [N_BITS-1:0]  i_rx_data;
  logic               i_rx_done;
  logic [N_BITS-1:0]  i_alu_result;
  logic               i_tx_done;
  logic [N_BITS-1:0]  o_alu_a;
  logic [N_BITS-1:0]  o_alu_b;
  logic [OP_BITS-1:0] o_alu_op;
  logic [N_BITS-1:0]  o_tx_data;
  logic               o_tx_start;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  modport slave (
    input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op, o_tx_data,
    output o_tx_start, o_busy, o_timeout, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op, o_tx_data,
    input  o_tx_start, o_busy, o_timeout, o_overrun
  );
endinterface

// File: rtl/uart_alu_sequencer.sv
// Collects A, B and opcode bytes from uart_rx, drives the ALU, and launches one uart_tx
// transfer of the result; an inter-byte timeout discards partial frames.
module uart_alu_sequencer #(
  parameter int          N_BITS      = 8,
  parameter int          OP_BITS     = 6,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  uart_alu_sequencer_if.slave   io_seq
);

  localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_WAIT_TX
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_BITS-1:0]  r_alu_a, r_alu_b, r_tx_data;
  logic [OP_BITS-1:0] r_alu_op;
  logic               r_tx_start, r_timeout, r_overrun;

  logic w_load_a, w_load_b, w_load_op, w_load_tx;
  logic w_timeout, w_overrun, w_cnt_inc, w_cnt_hit;

  assign w_cnt_hit = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load_a    = 1'b0;
    w_load_b    = 1'b0;
    w_load_op   = 1'b0;
    w_load_tx   = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      S_WAIT_A: begin
        if (io_seq.i_rx_done) begin
          w_load_a    = 1'b1;
          w_state_nxt = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (io_seq.i_rx_done) begin
          w_load_b    = 1'b1;
          w_state_nxt = S_WAIT_OP;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_WAIT_A;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_WAIT_OP: begin
        if (io_seq.i_rx_done) begin
          w_load_op   = 1'b1;
          w_state_nxt = S_EXEC;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_WAIT_A;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      S_EXEC: begin
        // The ALU has settled over this cycle; its result is captured at the edge.
        w_load_tx   = 1'b1;
        w_overrun   = io_seq.i_rx_done;
        w_state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (io_seq.i_tx_done) begin
          w_load_a    = io_seq.i_rx_done;
          w_state_nxt = io_seq.i_rx_done ? S_WAIT_B : S_WAIT_A;
        end else begin
          w_overrun   = io_seq.i_rx_done;
        end
      end
      default: w_state_nxt = S_WAIT_A;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_WAIT_A;
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= w_load_tx;
      r_timeout  <= w_timeout;
      r_overrun  <= w_overrun;
      if (w_cnt_inc) r_cnt <= (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      else           r_cnt <= '0;
      if (w_load_a)  r_alu_a   <= io_seq.i_rx_data;
      if (w_load_b)  r_alu_b   <= io_seq.i_rx_data;
      if (w_load_op) r_alu_op  <= io_seq.i_rx_data[OP_BITS-1:0];
      if (w_load_tx) r_tx_data <= io_seq.i_alu_result;
    end
  end

  assign io_seq.o_alu_a    = r_alu_a;
  assign io_seq.o_alu_b    = r_alu_b;
  assign io_seq.o_alu_op   = r_alu_op;
  assign io_seq.o_tx_data  = r_tx_data;
  assign io_seq.o_tx_start = r_tx_start;
  assign io_seq.o_busy     = (r_state == S_EXEC) || (r_state == S_WAIT_TX);
  assign io_seq.o_timeout  = r_timeout;
  assign io_seq.o_overrun  = r_overrun;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Randomized frame-level bench for uart_alu_sequencer with a small ALU model and
// pulse counters; expectations come from the bytes the bench itself sends.
module tb_uart_alu_sequencer;

  localparam int TO_CYC = 100;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_start = 0;
  int   n_tmo = 0;
  int   n_ovr = 0;

  logic [5:0] ops [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

  uart_alu_sequencer_if #(.N_BITS(8), .OP_BITS(6)) bus ();

  uart_alu_sequencer #(.N_BITS(8), .OP_BITS(6), .TIMEOUT_CYC(TO_CYC)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_seq  (bus)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return a;
    endcase
  endfunction

  assign bus.i_alu_result = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_tx_start === 1'b1) n_start++;
    if (bus.o_timeout  === 1'b1) n_tmo++;
    if (bus.o_overrun  === 1'b1) n_ovr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, limit reached", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ops"}, {10'd0, bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}, 32'd0);
    check({tag, "_tx"}, {20'd0, bus.o_tx_data, bus.o_tx_start, bus.o_busy,
                         bus.o_timeout, bus.o_overrun}, 32'd0);
  endtask

  // One calculator frame. ovr: 0 none, 1 stray byte in WAIT_TX, 2 stray byte in EXEC.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input int g1, input int g2, input int ovr, input bit skip_a,
                           input bit chain, input logic [7:0] chain_b, input bit stop_in_tx);
    int s0, t0, o0;
    logic [7:0] exp;
    exp = alu_f(a, b, op[5:0]);
    t0  = n_tmo;
    o0  = n_ovr;
    if (!skip_a) send_byte(a);
    check("alu_a", bus.o_alu_a, a);
    idle(g1);
    send_byte(b);
    check("alu_b", bus.o_alu_b, b);
    idle(g2);
    s0 = n_start;
    send_byte(op);
    check("alu_op", bus.o_alu_op, op[5:0]);
    check("busy_exec", bus.o_busy, 1);
    check("start_early", bus.o_tx_start, 0);
    if (ovr == 2) send_byte(8'h5A);
    else          idle(1);
    check("start_pulse", bus.o_tx_start, 1);
    check("tx_data", bus.o_tx_data, exp);
    if (ovr == 2) check("overrun_exec", bus.o_overrun, 1);
    idle(1);
    check("start_end", bus.o_tx_start, 0);
    check("busy_tx", bus.o_busy, 1);
    if (ovr == 1) begin
      send_byte(8'h55);
      check("overrun_tx", bus.o_overrun, 1);
      check("tx_hold_ovr", bus.o_tx_data, exp);
    end
    if (stop_in_tx) return;
    idle($urandom_range(0, 4));
    bus.i_tx_done = 1'b1;
    if (chain) begin
      bus.i_rx_done = 1'b1;
      bus.i_rx_data = chain_b;
    end
    @(posedge clk);
    #1;
    bus.i_tx_done = 1'b0;
    bus.i_rx_done = 1'b0;
    check("busy_done", bus.o_busy, 0);
    check("tx_hold", bus.o_tx_data, exp);
    check("overrun_done", bus.o_overrun, 0);
    if (chain) check("chain_a", bus.o_alu_a, chain_b);
    idle(1);
    check("n_start", n_start - s0, 1);
    check("n_tmo", n_tmo - t0, 0);
    check("n_ovr", n_ovr - o0, (ovr != 0) ? 1 : 0);
  endtask

  task automatic timeout_case(input bit in_op);
    int t0;
    t0 = n_tmo;
    send_byte(8'($urandom));
    if (in_op) begin
      idle(5);
      send_byte(8'($urandom));
    end
    idle(TO_CYC - 1);
    check("tmo_early", bus.o_timeout, 0);
    check("tmo_cnt_early", n_tmo - t0, 0);
    idle(1);
    check("tmo_pulse", bus.o_timeout, 1);
    check("tmo_busy", bus.o_busy, 0);
    idle(1);
    check("tmo_end", bus.o_timeout, 0);
    check("tmo_cnt", n_tmo - t0, 1);
  endtask

  task automatic reset_pulse(input string tag);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    bit         chain_prev;
    logic [7:0] cb;
    rst = 1'b0;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    run_frame(8'h01, 8'h02, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0);
    run_frame(8'hFF, 8'h01, 8'h20, 2, 1, 0, 0, 0, 8'h00, 0);

    timeout_case(0);
    run_frame(8'h03, 8'h04, 8'h20, 1, 1, 0, 0, 0, 8'h00, 0);
    check("add_07", bus.o_tx_data, 8'h07);
    timeout_case(1);

    run_frame(8'h10, 8'h20, 8'h26, 0, 0, 1, 0, 0, 8'h00, 0);
    run_frame(8'h40, 8'h0F, 8'h22, 0, 0, 2, 0, 0, 8'h00, 0);

    run_frame(8'h11, 8'h22, 8'h20, 0, 0, 0, 0, 1, 8'h09, 0);
    run_frame(8'h09, 8'h30, 8'h20, 3, 0, 0, 1, 0, 8'h00, 0);

    // Bytes landing exactly on the would-be timeout cycle are accepted.
    run_frame(8'h21, 8'h12, 8'h25, TO_CYC - 1, TO_CYC - 1, 0, 0, 0, 8'h00, 0);

    bus.i_tx_done = 1'b1;
    idle(1);
    bus.i_tx_done = 1'b0;
    check("tx_done_idle", bus.o_busy, 0);

    send_byte(8'hA5);
    send_byte(8'h3C);
    reset_pulse("rst_op");
    run_frame(8'h05, 8'h06, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0);
    run_frame(8'hC3, 8'h5A, 8'h24, 0, 0, 0, 0, 0, 8'h00, 1);
    reset_pulse("rst_tx");
    run_frame(8'h07, 8'h08, 8'h20, 0, 0, 0, 0, 0, 8'h00, 0);

    chain_prev = 1'b0;
    cb = 8'h00;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] a, b, op, nb;
      int g1, g2, ovr;
      bit ch;
      a   = chain_prev ? cb : 8'($urandom);
      b   = 8'($urandom);
      op  = {2'($urandom), ops[$urandom_range(0, 5)]};
      g1  = (!chain_prev && $urandom_range(0, 6) == 0) ? TO_CYC - 1 : $urandom_range(0, 10);
      g2  = ($urandom_range(0, 6) == 0) ? TO_CYC - 1 : $urandom_range(0, 10);
      ovr = $urandom_range(0, 2);
      ch  = ($urandom_range(0, 3) == 0);
      nb  = 8'($urandom);
      run_frame(a, b, op, g1, g2, ovr, chain_prev, ch, nb, 0);
      chain_prev = ch;
      cb = nb;
    end
    if (chain_prev) run_frame(cb, 8'h01, 8'h20, 0, 0, 0, 1, 0, 8'h00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
